// File: rtl/door_timeout_timer.sv
// Multi-door open-timeout timer: per-door saturating open-cycle counters with level, pulse and
// aggregate timeout outputs. Define TIMEOUT_WARN_EN to add the pre-timeout aviso output.
module door_timeout_timer #(
  parameter int unsigned N_PUERTAS   = 2,
  parameter int unsigned CICLOS      = 100,
  parameter int unsigned ANCHO       = 8
`ifdef TIMEOUT_WARN_EN
  ,
  parameter int unsigned WARN_CICLOS = 10
`endif
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [2*N_PUERTAS-1:0] estado,
  input  logic [N_PUERTAS-1:0]   obstruccion,
  output logic [N_PUERTAS-1:0]   timeout,
  output logic [N_PUERTAS-1:0]   timeout_pulso,
  output logic                   timeout_any
`ifdef TIMEOUT_WARN_EN
  ,
  output logic [N_PUERTAS-1:0]   aviso
`endif
);

  localparam logic [ANCHO-1:0] CntMax = ANCHO'(CICLOS);
  localparam logic [1:0]       StOpen = 2'b01;

  logic [ANCHO-1:0]     cnt_q [N_PUERTAS];
  logic [ANCHO-1:0]     cnt_d [N_PUERTAS];
  logic [N_PUERTAS-1:0] pulso_q;

  always_comb begin
    for (int i = 0; i < int'(N_PUERTAS); i++) begin
      cnt_d[i] = cnt_q[i];
      if (estado[2*i +: 2] != StOpen || obstruccion[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < CntMax) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(N_PUERTAS); i++) begin
        cnt_q[i] <= '0;
      end
      pulso_q <= '0;
    end else begin
      for (int i = 0; i < int'(N_PUERTAS); i++) begin
        cnt_q[i]   <= cnt_d[i];
        // Only the CICLOS-1 -> CICLOS step fires; holding at saturation does not.
        pulso_q[i] <= (cnt_d[i] == CntMax) && (cnt_q[i] != CntMax);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < int'(N_PUERTAS); i++) begin
      timeout[i] = (cnt_q[i] == CntMax);
    end
  end

  assign timeout_pulso = pulso_q;
  assign timeout_any   = |timeout;

`ifdef TIMEOUT_WARN_EN
  localparam logic [ANCHO-1:0] CntWarn = ANCHO'(CICLOS - WARN_CICLOS);

  always_comb begin
    for (int i = 0; i < int'(N_PUERTAS); i++) begin
      aviso[i] = (cnt_q[i] >= CntWarn) && (cnt_q[i] < CntMax);
    end
  end
`endif

endmodule

// File: tb/tb_door_timeout_timer.sv
// Directed bench for door_timeout_timer with CICLOS=8, N_PUERTAS=2 (WARN_CICLOS=3 if enabled).
module tb_door_timeout_timer;

  localparam int unsigned N = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [2*N-1:0] estado;
  logic [N-1:0]   obstruccion;
  logic [N-1:0]   timeout;
  logic [N-1:0]   timeout_pulso;
  logic           timeout_any;
`ifdef TIMEOUT_WARN_EN
  logic [N-1:0]   aviso;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

`ifdef TIMEOUT_WARN_EN
  door_timeout_timer #(
    .N_PUERTAS(N), .CICLOS(8), .ANCHO(8), .WARN_CICLOS(3)
  ) dut (
    .clk(clk), .reset(reset), .estado(estado), .obstruccion(obstruccion),
    .timeout(timeout), .timeout_pulso(timeout_pulso), .timeout_any(timeout_any),
    .aviso(aviso)
  );
`else
  door_timeout_timer #(
    .N_PUERTAS(N), .CICLOS(8), .ANCHO(8)
  ) dut (
    .clk(clk), .reset(reset), .estado(estado), .obstruccion(obstruccion),
    .timeout(timeout), .timeout_pulso(timeout_pulso), .timeout_any(timeout_any)
  );
`endif

  task automatic do_reset();
    reset       = 1'b1;
    estado      = '0;
    obstruccion = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    estado      = 4'b0101;
    obstruccion = '0;
    #2;
    n_checks++;
    if ({timeout, timeout_pulso, timeout_any} !== 5'b0)
      $display("FAIL reset_outputs: got %b expected 00000", {timeout, timeout_pulso, timeout_any});
    else n_pass++;
    do_reset();
  endtask

  task automatic test_basic();
    do_reset();
    estado = 4'b0001;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_checks++;
      if ({timeout, timeout_pulso, timeout_any} !==
          {1'b0, (e >= 8), 1'b0, (e == 8), (e >= 8)})
        $display("FAIL basic_edge%0d: got to=%b tp=%b any=%b expected to=0%b tp=0%b any=%b",
                 e, timeout, timeout_pulso, timeout_any, (e >= 8), (e == 8), (e >= 8));
      else n_pass++;
    end
  endtask

  task automatic test_obstruction();
    do_reset();
    estado = 4'b0001;
    for (int e = 1; e <= 14; e++) begin
      obstruccion = {1'b0, (e == 5)};
      tick();
      n_checks++;
      if (timeout[0] !== (e >= 13) || timeout_pulso[0] !== (e == 13))
        $display("FAIL obstruction_edge%0d: got to=%b tp=%b expected to=%b tp=%b",
                 e, timeout[0], timeout_pulso[0], (e >= 13), (e == 13));
      else n_pass++;
    end
    obstruccion = '0;
  endtask

  task automatic test_close();
    do_reset();
    estado = 4'b0001;
    for (int e = 1; e <= 11; e++) tick();
    n_checks++;
    if (timeout[0] !== 1'b1) $display("FAIL close_pre: got to=%b expected to=1", timeout[0]);
    else n_pass++;
    estado = 4'b0000;
    for (int e = 12; e <= 14; e++) begin
      tick();
      n_checks++;
      if ({timeout[0], timeout_pulso[0], timeout_any} !== 3'b000)
        $display("FAIL close_edge%0d: got to=%b tp=%b any=%b expected 0 0 0",
                 e, timeout[0], timeout_pulso[0], timeout_any);
      else n_pass++;
    end
    // Reopening must take a full CICLOS again, proving the counter was cleared.
    estado = 4'b0001;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_checks++;
      if (timeout[0] !== (e == 8) || timeout_pulso[0] !== (e == 8))
        $display("FAIL reopen_edge%0d: got to=%b tp=%b expected to=%b tp=%b",
                 e, timeout[0], timeout_pulso[0], (e == 8), (e == 8));
      else n_pass++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    estado = 4'b0101;
    for (int e = 1; e <= 8; e++) tick();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({timeout, timeout_pulso, timeout_any} !== 5'b0)
      $display("FAIL async_clear: got %b expected 00000", {timeout, timeout_pulso, timeout_any});
    else n_pass++;
    @(negedge clk);
    reset  = 1'b0;
    estado = 4'b0001;
    for (int e = 1; e <= 4; e++) tick();
    #2 reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      n_checks++;
      if (timeout[0] !== (e == 8) || timeout_pulso[0] !== (e == 8))
        $display("FAIL async_restart_edge%0d: got to=%b tp=%b expected to=%b tp=%b",
                 e, timeout[0], timeout_pulso[0], (e == 8), (e == 8));
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    estado = 4'b0101;
    for (int e = 1; e <= 7; e++) tick();
    tick();
    n_checks++;
    if (timeout_pulso !== 2'b11 || timeout !== 2'b11)
      $display("FAIL simul_edge8: got tp=%b to=%b expected tp=11 to=11", timeout_pulso, timeout);
    else n_pass++;
    tick();
    n_checks++;
    if (timeout_pulso !== 2'b00 || timeout !== 2'b11)
      $display("FAIL simul_edge9: got tp=%b to=%b expected tp=00 to=11", timeout_pulso, timeout);
    else n_pass++;
    estado = 4'b1001;
    tick();
    n_checks++;
    if (timeout !== 2'b01 || timeout_pulso !== 2'b00 || timeout_any !== 1'b1)
      $display("FAIL simul_edge10: got to=%b tp=%b any=%b expected to=01 tp=00 any=1",
               timeout, timeout_pulso, timeout_any);
    else n_pass++;
  endtask

`ifdef TIMEOUT_WARN_EN
  task automatic test_warn();
    do_reset();
    estado = 4'b0001;
    for (int e = 1; e <= 9; e++) begin
      tick();
      n_checks++;
      if (aviso !== {1'b0, (e >= 5 && e <= 7)})
        $display("FAIL warn_edge%0d: got aviso=%b expected 0%b", e, aviso, (e >= 5 && e <= 7));
      else n_pass++;
    end
    do_reset();
    estado = 4'b0001;
    for (int e = 1; e <= 6; e++) tick();
    obstruccion = 2'b01;
    tick();
    n_checks++;
    if (aviso !== 2'b00) $display("FAIL warn_obstruct: got aviso=%b expected 00", aviso);
    else n_pass++;
    obstruccion = '0;
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_obstruction();
    test_close();
    test_async_reset();
    test_simultaneous();
`ifdef TIMEOUT_WARN_EN
    test_warn();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
